switch_format_unit: RTL and testbench

SWITCH_FORMAT_UNIT -- requirements
Module: switch_format_unit

---
 rtl/switch_fmt_pkg.sv | 33 +++
 rtl/switch_format_unit_dabble_digit.sv | 9 +
 rtl/switch_format_unit.sv | 157 +++++++++++++++
 tb/tb_switch_format_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_fmt_pkg.sv
// Shared types and constants for the switch formatting unit.
// acc_digits() sizes the BCD accumulator so it can hold the widest raw switch value.
package switch_fmt_pkg;

   typedef enum logic [1:0] {
      FMT_BIN       = 2'd0,
      FMT_BCD       = 2'd1,
      FMT_BCD_BLANK = 2'd2,
      FMT_ALT_BIN   = 2'd3
   } fmt_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } fsm_state_t;

   localparam logic [3:0] BLANK_DIGIT = 4'hF;

   // Number of decimal digits needed for 2^in_w-1.
   function automatic int acc_digits(input int in_w);
      longint v;
      int     d;
      v = (longint'(1) << in_w) - 1;
      d = 0;
      do begin
         v = v / 10;
         d++;
      end while (v > 0);
      return d;
   endfunction

endpackage

// File: rtl/switch_format_unit_dabble_digit.sv
// One BCD digit correction step of double dabble: add 3 when the digit is 5 or more.
module dabble_digit (
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);

   assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/switch_format_unit.sv
// Snapshots the switch inputs, converts them to BCD with a serial double-dabble
// engine, and presents the held result as binary, BCD or zero-blanked BCD.
module switch_format_unit
   import switch_fmt_pkg::*;
#(
   parameter int IN_W   = 12,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [IN_W-1:0]       switches_inputs,
   input  logic [1:0]            format_mode,
   output logic [4*DIGITS-1:0]   switches_subsystem_outputs,
   output logic                  data_valid,
   output logic                  busy,
   output logic                  overflow
);

   localparam int OUT_W = 4 * DIGITS;
   localparam int ACC_D = acc_digits(IN_W);
   localparam int ACC_W = 4 * ACC_D;
   localparam int PAD_D = (ACC_D > DIGITS) ? ACC_D : DIGITS;
   localparam int PAD_W = 4 * PAD_D;
   localparam int CNT_W = $clog2(IN_W + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

   generate
      if (IN_W < 1 || IN_W > 20) begin : g_bad_in_w
         $error("switch_format_unit: IN_W must be within 1..20");
      end
      if (OUT_W < IN_W) begin : g_bad_digits
         $error("switch_format_unit: 4*DIGITS must be >= IN_W");
      end
   endgenerate

   fsm_state_t        r_state;
   logic [IN_W-1:0]   r_sw_q;
   logic [IN_W-1:0]   r_src_q;
   logic [IN_W-1:0]   r_shift;
   logic [ACC_W-1:0]  r_acc;
   logic [CNT_W-1:0]  r_cnt;
   logic [IN_W-1:0]   r_bin_hold;
   logic [OUT_W-1:0]  r_bcd_hold;
   logic              r_overflow;
   logic              r_data_valid;
   logic              r_busy;

   logic [ACC_W-1:0]  w_dabbled;
   logic [ACC_W-1:0]  w_acc_shifted;
   logic [PAD_W-1:0]  w_acc_pad;
   logic [OUT_W-1:0]  w_acc_low;
   logic              w_high_nz;
   logic [OUT_W-1:0]  w_blanked;
   logic [OUT_W-1:0]  w_out;

   genvar gi;
   generate
      for (gi = 0; gi < ACC_D; gi++) begin : g_dabble
         dabble_digit u_dabble (
            .i_digit (r_acc[4*gi +: 4]),
            .o_digit (w_dabbled[4*gi +: 4])
         );
      end
   endgenerate

   assign w_acc_shifted = {w_dabbled[ACC_W-2:0], r_shift[IN_W-1]};
   assign w_acc_pad     = PAD_W'(r_acc);
   assign w_acc_low     = w_acc_pad[OUT_W-1:0];

   // Any nonzero digit beyond the presented ones means the value cannot be shown.
   always_comb begin
      w_high_nz = 1'b0;
      for (int i = DIGITS; i < PAD_D; i++) begin
         w_high_nz = w_high_nz | (|w_acc_pad[4*i +: 4]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_sw_q       <= '0;
         r_src_q      <= '0;
         r_shift      <= '0;
         r_acc        <= '0;
         r_cnt        <= '0;
         r_bin_hold   <= '0;
         r_bcd_hold   <= '0;
         r_overflow   <= 1'b0;
         r_data_valid <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_sw_q       <= switches_inputs;
         r_data_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_sw_q != r_src_q) begin
                  r_src_q <= r_sw_q;
                  r_shift <= r_sw_q;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               r_acc   <= w_acc_shifted;
               r_shift <= r_shift << 1;
               r_cnt   <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST_CNT) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_bin_hold   <= r_src_q;
               r_bcd_hold   <= w_high_nz ? {DIGITS{4'd9}} : w_acc_low;
               r_overflow   <= w_high_nz;
               r_data_valid <= 1'b1;
               r_busy       <= 1'b0;
               r_state      <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Blank zero digits from the top down until the first nonzero; digit 0 always shows.
   always_comb begin : p_blank
      logic v_lead;
      v_lead    = 1'b1;
      w_blanked = r_bcd_hold;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (r_bcd_hold[4*i +: 4] != 4'd0) begin
            v_lead = 1'b0;
         end
         if (v_lead) begin
            w_blanked[4*i +: 4] = BLANK_DIGIT;
         end
      end
   end

   always_comb begin
      case (fmt_mode_t'(format_mode))
         FMT_BCD:       w_out = r_bcd_hold;
         FMT_BCD_BLANK: w_out = w_blanked;
         default:       w_out = OUT_W'(r_bin_hold);
      endcase
   end

   assign switches_subsystem_outputs = w_out;
   assign data_valid                 = r_data_valid;
   assign busy                       = r_busy;
   assign overflow                   = r_overflow;

endmodule

// File: tb/tb_switch_format_unit.sv
// Randomized scoreboard bench: stimulus pushes expected conversions, a monitor
// pops and checks them on each data_valid against an arithmetic BCD model.
module tb_switch_format_unit;

   typedef struct {
      int v;
      int due;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] sw_a = '0;
   logic [9:0]  sw_b = '0;
   logic [1:0]  mode_a = 2'd1;
   logic [1:0]  mode_b = 2'd1;
   logic [15:0] out_a;
   logic [11:0] out_b;
   logic        dv_a, dv_b, busy_a, busy_b, ovf_a, ovf_b;

   exp_t q_a[$];
   exp_t q_b[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   cur_a = 0;
   int   cur_b = 0;

   switch_format_unit #(.IN_W(12), .DIGITS(4)) u_dut_a (
      .clk                        (clk),
      .reset                      (reset),
      .switches_inputs            (sw_a),
      .format_mode                (mode_a),
      .switches_subsystem_outputs (out_a),
      .data_valid                 (dv_a),
      .busy                       (busy_a),
      .overflow                   (ovf_a)
   );

   switch_format_unit #(.IN_W(10), .DIGITS(3)) u_dut_b (
      .clk                        (clk),
      .reset                      (reset),
      .switches_inputs            (sw_b),
      .format_mode                (mode_b),
      .switches_subsystem_outputs (out_b),
      .data_valid                 (dv_b),
      .busy                       (busy_b),
      .overflow                   (ovf_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int max_val(input int digits);
      int m;
      m = 1;
      for (int i = 0; i < digits; i++) m = m * 10;
      return m - 1;
   endfunction

   // Expected output word for value v shown in the given mode.
   function automatic int fmt_model(input int v, input int mode, input int digits);
      int vv, r, d, pw;
      bit lead;
      if (mode == 0 || mode == 3) return v;
      vv   = (v > max_val(digits)) ? max_val(digits) : v;
      r    = 0;
      lead = 1'b1;
      for (int i = digits - 1; i >= 0; i--) begin
         pw = 1;
         for (int j = 0; j < i; j++) pw = pw * 10;
         d = (vv / pw) % 10;
         if (d != 0) lead = 1'b0;
         if (mode == 2 && lead && i != 0) d = 15;
         r = (r << 4) | d;
      end
      return r;
   endfunction

   task automatic check(input string name, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic monitor();
      exp_t e;
      int   w;
      forever begin
         @(negedge clk);
         if (dv_a) begin
            if (q_a.size() == 0) begin
               check("dv_a_unexpected", 1, 0);
            end else begin
               e = q_a.pop_front();
               w = fmt_model(e.v, int'(mode_a), 4);
               $display("conv A v=%0d out=%h ovf=%b cyc=%0d", e.v, out_a, ovf_a, cyc);
               check("conv_a_cycle", cyc, e.due);
               check("conv_a_out", int'(out_a), w);
               check("conv_a_ovf", int'(ovf_a), int'(e.v > max_val(4)));
               check("conv_a_busy", int'(busy_a), 0);
            end
         end
         if (dv_b) begin
            if (q_b.size() == 0) begin
               check("dv_b_unexpected", 1, 0);
            end else begin
               e = q_b.pop_front();
               w = fmt_model(e.v, int'(mode_b), 3);
               $display("conv B v=%0d out=%h ovf=%b cyc=%0d", e.v, out_b, ovf_b, cyc);
               check("conv_b_cycle", cyc, e.due);
               check("conv_b_out", int'(out_b), w);
               check("conv_b_ovf", int'(ovf_b), int'(e.v > max_val(3)));
               check("conv_b_busy", int'(busy_b), 0);
            end
         end
      end
   endtask

   // Drive a new value while the unit is idle; latency is IN_W+2 from the sampling edge.
   task automatic apply_a(input int v, output int c);
      @(negedge clk);
      c = cyc;
      if (v != cur_a) q_a.push_back('{v: v, due: c + 1 + 14});
      sw_a  = 12'(v);
      cur_a = v;
   endtask

   task automatic apply_b(input int v);
      @(negedge clk);
      if (v != cur_b) q_b.push_back('{v: v, due: cyc + 1 + 12});
      sw_b  = 10'(v);
      cur_b = v;
   endtask

   task automatic wait_drain(input int max_cycles);
      int k;
      k = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && k < max_cycles) begin
         @(negedge clk);
         k++;
      end
      check("drain_pending", q_a.size() + q_b.size(), 0);
      q_a.delete();
      q_b.delete();
   endtask

   task automatic check_modes_a();
      for (int m = 0; m < 4; m++) begin
         @(negedge clk);
         mode_a = 2'(m);
         #1;
         check("mode_a_out", int'(out_a), fmt_model(cur_a, m, 4));
         check("mode_a_nodv", int'(dv_a), 0);
      end
   endtask

   initial begin
      int c;
      int v;
      int rv[4];
      rv[0] = 7; rv[1] = 0; rv[2] = 1024; rv[3] = 12'hABC;

      fork
         monitor();
      join_none

      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", int'(busy_a), 0);
      check("rst_dv", int'(dv_a), 0);
      check("rst_ovf", int'(ovf_a), 0);
      check_modes_a();

      @(negedge clk);
      reset  = 1'b0;
      mode_a = 2'd1;
      apply_a(12'hFFF, c);
      wait_drain(40);
      @(negedge clk);
      #1;
      check("busy_after_fff", int'(busy_a), 0);

      for (int i = 0; i < 4; i++) begin
         mode_a = (i == 3) ? 2'd3 : 2'd2;
         apply_a(rv[i], c);
         wait_drain(40);
         check_modes_a();
      end

      // Input change in the middle of a conversion is picked up afterwards.
      mode_a = 2'd1;
      apply_a(100, c);
      repeat (5) @(negedge clk);
      sw_a  = 12'd200;
      cur_a = 200;
      q_a.push_back('{v: 200, due: c + 15 + 14});
      wait_drain(60);

      for (int i = 0; i < 20; i++) begin
         mode_a = 2'($urandom_range(0, 3));
         v      = int'($urandom_range(0, 4095));
         apply_a(v, c);
         wait_drain(40);
         check_modes_a();
      end

      mode_b = 2'd1;
      apply_b(1000);
      wait_drain(40);
      apply_b(999);
      wait_drain(40);
      for (int i = 0; i < 6; i++) begin
         mode_b = 2'($urandom_range(0, 3));
         apply_b(int'($urandom_range(0, 1023)));
         wait_drain(40);
      end
      mode_b = 2'd1;
      apply_b(999);
      wait_drain(40);

      // Reset in the middle of a conversion aborts it.
      mode_a = 2'd1;
      apply_a(555, c);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      q_a.delete();
      repeat (2) @(negedge clk);
      mode_a = 2'd0;
      #1;
      check("abort_out", int'(out_a), 0);
      check("abort_busy", int'(busy_a), 0);
      check("abort_dv", int'(dv_a), 0);
      check("abort_ovf", int'(ovf_a), 0);
      @(negedge clk);
      mode_a = 2'd1;
      reset  = 1'b0;
      q_a.push_back('{v: cur_a, due: cyc + 1 + 14});
      q_b.push_back('{v: cur_b, due: cyc + 1 + 12});
      wait_drain(40);
      repeat (20) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
